stage_d: RTL and testbench
==========================

Name: stage_d

Overview:
- Instruction decode stage of the Polaris RV64I pipeline. Sits directly downstream of the instruction fetch stage.
- Captures each instruction word and its PC whenever the F-bus acknowledges a fetch.
- Decodes the word into register indices, a sign-extended 64-bit immediate, a format code and an operation class, and presents them as one registered pipeline slot to the execute stage.
- Fetch never stalls itself, so a one-entry skid buffer absorbs one fetch that arrives while downstream is stalled.

Parameters:
- RESET_PC, 62'h3FFF_FFFF_FFFF_FFC0, word address loaded into d_pc_o on reset. This is byte address FFFF_FFFF_FFFF_FF00 >> 2.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- reset_i  in  1  synchronous reset, active-high
- f_ack_i  in  1  qualified fetch acknowledge (ack & cyc); f_pc_i/f_inst_i are valid this cycle
- f_pc_i  in  62  [63:2] word address of the fetched instruction
- f_inst_i  in  32  fetched instruction word
- stall_i  in  1  downstream cannot accept a slot this cycle
- flush_i  in  1  discard all held instructions (branch/trap redirect)
- f_hold_o  out  1  registered; skid buffer occupied, asks fetch to pause
- d_valid_o  out  1  slot holds a real instruction
- d_pc_o  out  62  [63:2] PC of slot
- d_inst_o  out  32  raw instruction word of slot
- d_rd_o, d_rs1_o, d_rs2_o  out  5 each  inst[11:7], [19:15], [24:20]
- d_funct3_o  out  3  inst[14:12]
- d_alt_o  out  1  inst[30] (SUB/SRA select)
- d_fmt_o  out  3  0=R 1=I 2=S 3=B 4=U 5=J 7=none
- d_class_o  out  4  operation class (see Behaviour)
- d_imm_o  out  64  sign-extended immediate
- d_we_o  out  1  instruction writes rd and rd != 0
- d_illegal_o  out  1  unrecognised encoding
- d_overrun_o  out  1  sticky: a fetch was lost

Behaviour:
- Reset: all outputs 0 except d_pc_o=RESET_PC; skid empty; f_hold_o=0; d_overrun_o=0.
- Slot load (no reset, no flush): if !stall_i or !d_valid_o, the slot loads from the skid if it is full (skid then empties), else from the F inputs when f_ack_i=1, else d_valid_o<=0.
- Skid capture: when the slot does not load (stall_i && d_valid_o) and f_ack_i=1, the incoming fetch goes into the skid if it is empty.
- Same-cycle refill: if the skid is emptied into the slot and f_ack_i=1 in the same cycle, the new fetch enters the skid.
- Overrun: if the skid is full and the slot does not load, or the skid stays full, an arriving f_ack_i sets d_overrun_o and the word is dropped.
- Flush: flush_i has priority over stall/ack. d_valid_o<=0, skid emptied, d_overrun_o<=0, and a fetch arriving the same cycle is discarded.
- While stalled with d_valid_o=1, all d_* outputs hold.
- Latency: fetch ack in cycle N -> d_valid_o=1 in N+1 (skid path: the cycle after stall_i drops).
- f_hold_o is registered and equals skid occupancy.
- Decoding is registered: computed from the selected source word and stored with the slot, not computed after the register.
- Opcode classes (inst[6:0]):
  - 0110111 LUI=1, U
  - 0010111 AUIPC=2, U
  - 1101111 JAL=3, J
  - 1100111 JALR=4, I
  - 1100011 BRANCH=5, B
  - 0000011 LOAD=6, I
  - 0100011 STORE=7, S
  - 0010011 OPIMM=8, I
  - 0011011 OPIMM32=9, I
  - 0110011 OP=10, R
  - 0111011 OP32=11, R
  - 0001111 FENCE=12, I
  - 1110011 SYSTEM=13, I
- Illegal: any other opcode -> class 15, fmt 7, d_illegal_o=1, d_we_o=0, imm 0.
- Immediates, all sign-extended from inst[31] to 64 bits:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'h0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R: 0
- d_we_o=1 for classes 1,2,3,4,6,8,9,10,11,13 when rd != 0; 0 for BRANCH, STORE, FENCE, illegal.
- Register fields are emitted raw regardless of format.

Test Plan:
- Reset: hold reset_i 2 cycles -> d_valid_o=0, d_pc_o=3FFF_FFFF_FFFF_FFC0, f_hold_o=0.
- ADDI: f_ack_i=1, f_inst_i=0x00500093, f_pc_i=0x10 -> next cycle d_valid_o=1, d_pc_o=0x10, rd=1, rs1=0, class 8, fmt 1, imm=5, we=1.
- LUI sign extension: 0x80000137 -> imm 0xFFFF_FFFF_8000_0000, rd=2, class 1. BEQ 0xFE000EE3 -> imm 0xFFFF_FFFF_FFFF_FFFC, class 5, we=0.
- Stall/skid: slot holds A; stall_i=1 and word B acked -> slot still A, f_hold_o=1 next cycle. Drop stall -> slot=B, f_hold_o=0. A third ack during the same stall instead -> d_overrun_o=1.
- Flush: skid full, flush_i=1 with a simultaneous f_ack_i -> next cycle d_valid_o=0, f_hold_o=0, d_overrun_o=0.
- Illegal: 0x00000000 and 0xFFFFFFFF -> d_illegal_o=1, class 15, we=0. ADDI x0 (0x00000013) -> we=0, illegal=0.

Source files
------------

// File: rtl/stage_d.sv
// stage_d: RV64I instruction decode stage with a one-entry fetch skid buffer.
// Decode is performed on the word selected for the slot (skid or fetch bus)
// and registered together with it, so all d_* outputs come straight from flops.
module stage_d #(
  parameter logic [61:0] RESET_PC = 62'h3FFF_FFFF_FFFF_FFC0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        f_ack_i,
  input  logic [61:0] f_pc_i,
  input  logic [31:0] f_inst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        f_hold_o,
  output logic        d_valid_o,
  output logic [61:0] d_pc_o,
  output logic [31:0] d_inst_o,
  output logic [4:0]  d_rd_o,
  output logic [4:0]  d_rs1_o,
  output logic [4:0]  d_rs2_o,
  output logic [2:0]  d_funct3_o,
  output logic        d_alt_o,
  output logic [2:0]  d_fmt_o,
  output logic [3:0]  d_class_o,
  output logic [63:0] d_imm_o,
  output logic        d_we_o,
  output logic        d_illegal_o,
  output logic        d_overrun_o
);

  localparam int unsigned PC_W   = 62;
  localparam int unsigned INST_W = 32;
  localparam int unsigned XLEN   = 64;

  // Major opcodes, inst[6:0]
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  // Operation classes
  localparam logic [3:0] CLS_LUI     = 4'd1;
  localparam logic [3:0] CLS_AUIPC   = 4'd2;
  localparam logic [3:0] CLS_JAL     = 4'd3;
  localparam logic [3:0] CLS_JALR    = 4'd4;
  localparam logic [3:0] CLS_BRANCH  = 4'd5;
  localparam logic [3:0] CLS_LOAD    = 4'd6;
  localparam logic [3:0] CLS_STORE   = 4'd7;
  localparam logic [3:0] CLS_OPIMM   = 4'd8;
  localparam logic [3:0] CLS_OPIMM32 = 4'd9;
  localparam logic [3:0] CLS_OP      = 4'd10;
  localparam logic [3:0] CLS_OP32    = 4'd11;
  localparam logic [3:0] CLS_FENCE   = 4'd12;
  localparam logic [3:0] CLS_SYSTEM  = 4'd13;
  localparam logic [3:0] CLS_ILL     = 4'd15;

  // Instruction formats
  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  // Slot registers
  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [INST_W-1:0] r_inst;
  logic [4:0]        r_rd;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [2:0]        r_funct3;
  logic              r_alt;
  logic [2:0]        r_fmt;
  logic [3:0]        r_class;
  logic [XLEN-1:0]   r_imm;
  logic              r_we;
  logic              r_illegal;

  // Skid buffer and sticky overrun flag
  logic              r_sk_full;
  logic [PC_W-1:0]   r_sk_pc;
  logic [INST_W-1:0] r_sk_inst;
  logic              r_overrun;

  // Source selection and decode results
  logic              w_slot_load;
  logic              w_src_avail;
  logic [PC_W-1:0]   w_src_pc;
  logic [INST_W-1:0] w_src_inst;
  logic [6:0]        w_opcode;
  logic [3:0]        w_class;
  logic [2:0]        w_fmt;
  logic              w_illegal;
  logic [XLEN-1:0]   w_imm;
  logic              w_wr_class;
  logic              w_we;

  // Slot accepts a new entry whenever downstream takes the old one or it is empty
  assign w_slot_load = !stall_i || !r_valid;
  // The skid always holds the older word, so it has priority over the bus
  assign w_src_avail = r_sk_full || f_ack_i;
  assign w_src_pc    = r_sk_full ? r_sk_pc   : f_pc_i;
  assign w_src_inst  = r_sk_full ? r_sk_inst : f_inst_i;
  assign w_opcode    = w_src_inst[6:0];

  // Opcode to class/format lookup
  always_comb begin
    w_class   = CLS_ILL;
    w_fmt     = FMT_NONE;
    w_illegal = 1'b0;
    unique case (w_opcode)
      OPC_LUI:     begin w_class = CLS_LUI;     w_fmt = FMT_U; end
      OPC_AUIPC:   begin w_class = CLS_AUIPC;   w_fmt = FMT_U; end
      OPC_JAL:     begin w_class = CLS_JAL;     w_fmt = FMT_J; end
      OPC_JALR:    begin w_class = CLS_JALR;    w_fmt = FMT_I; end
      OPC_BRANCH:  begin w_class = CLS_BRANCH;  w_fmt = FMT_B; end
      OPC_LOAD:    begin w_class = CLS_LOAD;    w_fmt = FMT_I; end
      OPC_STORE:   begin w_class = CLS_STORE;   w_fmt = FMT_S; end
      OPC_OPIMM:   begin w_class = CLS_OPIMM;   w_fmt = FMT_I; end
      OPC_OPIMM32: begin w_class = CLS_OPIMM32; w_fmt = FMT_I; end
      OPC_OP:      begin w_class = CLS_OP;      w_fmt = FMT_R; end
      OPC_OP32:    begin w_class = CLS_OP32;    w_fmt = FMT_R; end
      OPC_FENCE:   begin w_class = CLS_FENCE;   w_fmt = FMT_I; end
      OPC_SYSTEM:  begin w_class = CLS_SYSTEM;  w_fmt = FMT_I; end
      default:     begin w_illegal = 1'b1; end
    endcase
  end

  // Sign-extended immediate assembled per format; R and illegal give zero
  always_comb begin
    w_imm = '0;
    case (w_fmt)
      FMT_I: w_imm = {{52{w_src_inst[31]}}, w_src_inst[31:20]};
      FMT_S: w_imm = {{52{w_src_inst[31]}}, w_src_inst[31:25], w_src_inst[11:7]};
      FMT_B: w_imm = {{51{w_src_inst[31]}}, w_src_inst[31], w_src_inst[7],
                      w_src_inst[30:25], w_src_inst[11:8], 1'b0};
      FMT_U: w_imm = {{32{w_src_inst[31]}}, w_src_inst[31:12], 12'h000};
      FMT_J: w_imm = {{43{w_src_inst[31]}}, w_src_inst[31], w_src_inst[19:12],
                      w_src_inst[20], w_src_inst[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  // Register write enable: classes that produce a result, suppressed for x0
  always_comb begin
    w_wr_class = 1'b0;
    case (w_class)
      CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LOAD, CLS_OPIMM,
      CLS_OPIMM32, CLS_OP, CLS_OP32, CLS_SYSTEM: w_wr_class = 1'b1;
      default: w_wr_class = 1'b0;
    endcase
    w_we = w_wr_class && (w_src_inst[11:7] != 5'd0);
  end

  // Pipeline slot: loads the selected word with its decode, or bubbles
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid   <= 1'b0;
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_funct3  <= '0;
      r_alt     <= 1'b0;
      r_fmt     <= '0;
      r_class   <= '0;
      r_imm     <= '0;
      r_we      <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_slot_load) begin
      r_valid <= w_src_avail;
      if (w_src_avail) begin
        r_pc      <= w_src_pc;
        r_inst    <= w_src_inst;
        r_rd      <= w_src_inst[11:7];
        r_rs1     <= w_src_inst[19:15];
        r_rs2     <= w_src_inst[24:20];
        r_funct3  <= w_src_inst[14:12];
        r_alt     <= w_src_inst[30];
        r_fmt     <= w_fmt;
        r_class   <= w_class;
        r_imm     <= w_imm;
        r_we      <= w_we;
        r_illegal <= w_illegal;
      end
    end
  end

  // Skid buffer: catches a fetch during a stall, refills when drained into the slot
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sk_full <= 1'b0;
      r_sk_pc   <= '0;
      r_sk_inst <= '0;
    end else if (flush_i) begin
      r_sk_full <= 1'b0;
    end else if (w_slot_load) begin
      if (r_sk_full) begin
        r_sk_full <= f_ack_i;
        if (f_ack_i) begin
          r_sk_pc   <= f_pc_i;
          r_sk_inst <= f_inst_i;
        end
      end
    end else if (f_ack_i && !r_sk_full) begin
      r_sk_full <= 1'b1;
      r_sk_pc   <= f_pc_i;
      r_sk_inst <= f_inst_i;
    end
  end

  // Sticky overrun: a fetch arrived with nowhere to go
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      r_overrun <= 1'b0;
    end else if (!w_slot_load && r_sk_full && f_ack_i) begin
      r_overrun <= 1'b1;
    end
  end

  assign f_hold_o    = r_sk_full;
  assign d_valid_o   = r_valid;
  assign d_pc_o      = r_pc;
  assign d_inst_o    = r_inst;
  assign d_rd_o      = r_rd;
  assign d_rs1_o     = r_rs1;
  assign d_rs2_o     = r_rs2;
  assign d_funct3_o  = r_funct3;
  assign d_alt_o     = r_alt;
  assign d_fmt_o     = r_fmt;
  assign d_class_o   = r_class;
  assign d_imm_o     = r_imm;
  assign d_we_o      = r_we;
  assign d_illegal_o = r_illegal;
  assign d_overrun_o = r_overrun;

endmodule

// File: tb/tb_stage_d.sv
// tb_stage_d: directed and randomized checks of stage_d against a queue-based model.
module tb_stage_d;

  localparam logic [61:0] RST_PC = 62'h3FFF_FFFF_FFFF_FFC0;
  localparam logic [6:0] OPC_TAB [13] = '{7'b0110111, 7'b0010111, 7'b1101111,
    7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0011011,
    7'b0110011, 7'b0111011, 7'b0001111, 7'b1110011};
  localparam logic [2:0] FMT_TAB [13] = '{3'd4, 3'd4, 3'd5, 3'd1, 3'd3, 3'd1,
    3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1, 3'd1};

  typedef struct packed {
    logic [3:0]  cls;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        we;
    logic        ill;
  } dec_t;

  typedef struct packed {
    logic [61:0] pc;
    logic [31:0] inst;
  } fe_t;

  logic        clk = 1'b0;
  logic        reset_i, f_ack_i, stall_i, flush_i;
  logic [61:0] f_pc_i;
  logic [31:0] f_inst_i;
  logic        f_hold_o, d_valid_o, d_alt_o, d_we_o, d_illegal_o, d_overrun_o;
  logic [61:0] d_pc_o;
  logic [31:0] d_inst_o;
  logic [4:0]  d_rd_o, d_rs1_o, d_rs2_o;
  logic [2:0]  d_funct3_o, d_fmt_o;
  logic [3:0]  d_class_o;
  logic [63:0] d_imm_o;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic        m_valid;
  fe_t         m_slot;
  dec_t        m_dec;
  fe_t         m_q[$];
  logic        m_ov;

  stage_d dut (
    .clk_i(clk), .reset_i(reset_i), .f_ack_i(f_ack_i), .f_pc_i(f_pc_i),
    .f_inst_i(f_inst_i), .stall_i(stall_i), .flush_i(flush_i),
    .f_hold_o(f_hold_o), .d_valid_o(d_valid_o), .d_pc_o(d_pc_o),
    .d_inst_o(d_inst_o), .d_rd_o(d_rd_o), .d_rs1_o(d_rs1_o), .d_rs2_o(d_rs2_o),
    .d_funct3_o(d_funct3_o), .d_alt_o(d_alt_o), .d_fmt_o(d_fmt_o),
    .d_class_o(d_class_o), .d_imm_o(d_imm_o), .d_we_o(d_we_o),
    .d_illegal_o(d_illegal_o), .d_overrun_o(d_overrun_o)
  );

  always #5 clk = ~clk;

  // Decode from the table: class is table index + 1; immediates via arithmetic shift
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    logic signed [63:0] t;
    d = '{cls: 4'hF, fmt: 3'd7, imm: 64'd0, we: 1'b0, ill: 1'b1};
    for (int i = 0; i < 13; i++)
      if (w[6:0] == OPC_TAB[i]) begin
        d.cls = 4'(i + 1);
        d.fmt = FMT_TAB[i];
        d.ill = 1'b0;
      end
    if (!d.ill) begin
      case (d.fmt)
        3'd1: begin t = {w[31:20], 52'd0}; d.imm = t >>> 52; end
        3'd2: begin t = {w[31:25], w[11:7], 52'd0}; d.imm = t >>> 52; end
        3'd3: begin t = {w[31], w[7], w[30:25], w[11:8], 1'b0, 51'd0}; d.imm = t >>> 51; end
        3'd4: begin t = {w[31:12], 44'd0}; d.imm = t >>> 32; end
        3'd5: begin t = {w[31], w[19:12], w[20], w[30:21], 1'b0, 43'd0}; d.imm = t >>> 43; end
        default: d.imm = 64'd0;
      endcase
      d.we = !(d.cls inside {4'd5, 4'd7, 4'd12}) && (w[11:7] != 5'd0);
    end
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Compare every output with the model; slot contents only matter when valid
  task automatic check_all();
    chk("valid", 64'(d_valid_o), 64'(m_valid));
    chk("hold", 64'(f_hold_o), 64'(m_q.size() != 0));
    chk("overrun", 64'(d_overrun_o), 64'(m_ov));
    if (m_valid) begin
      chk("pc", 64'(d_pc_o), 64'(m_slot.pc));
      chk("inst", 64'(d_inst_o), 64'(m_slot.inst));
      chk("rd", 64'(d_rd_o), 64'(m_slot.inst[11:7]));
      chk("rs1", 64'(d_rs1_o), 64'(m_slot.inst[19:15]));
      chk("rs2", 64'(d_rs2_o), 64'(m_slot.inst[24:20]));
      chk("funct3", 64'(d_funct3_o), 64'(m_slot.inst[14:12]));
      chk("alt", 64'(d_alt_o), 64'(m_slot.inst[30]));
      chk("fmt", 64'(d_fmt_o), 64'(m_dec.fmt));
      chk("class", 64'(d_class_o), 64'(m_dec.cls));
      chk("imm", d_imm_o, m_dec.imm);
      chk("we", 64'(d_we_o), 64'(m_dec.we));
      chk("illegal", 64'(d_illegal_o), 64'(m_dec.ill));
    end
  endtask

  // Advance model from the current inputs, clock once, then check
  task automatic step();
    fe_t f;
    f = '{pc: f_pc_i, inst: f_inst_i};
    if (reset_i) begin
      m_valid = 1'b0; m_slot = '{pc: RST_PC, inst: 32'd0}; m_q.delete(); m_ov = 1'b0;
    end else if (flush_i) begin
      m_valid = 1'b0; m_q.delete(); m_ov = 1'b0;
    end else if (!stall_i || !m_valid) begin
      if (m_q.size() != 0) begin
        m_slot = m_q.pop_front(); m_valid = 1'b1; m_dec = ref_decode(m_slot.inst);
        if (f_ack_i) m_q.push_back(f);
      end else if (f_ack_i) begin
        m_slot = f; m_valid = 1'b1; m_dec = ref_decode(f.inst);
      end else m_valid = 1'b0;
    end else if (f_ack_i) begin
      if (m_q.size() == 0) m_q.push_back(f);
      else m_ov = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic ack, input logic [61:0] pc, input logic [31:0] inst,
                       input logic stall, input logic flush);
    f_ack_i = ack; f_pc_i = pc; f_inst_i = inst; stall_i = stall; flush_i = flush;
  endtask

  initial begin
    logic [31:0] r;
    reset_i = 1'b1;
    drive(1'b0, 62'd0, 32'd0, 1'b0, 1'b0);
    m_dec = '0;
    step(); step();
    chk("rst_valid", 64'(d_valid_o), 64'd0);
    chk("rst_pc", 64'(d_pc_o), 64'h3FFF_FFFF_FFFF_FFC0);
    chk("rst_hold", 64'(f_hold_o), 64'd0);
    reset_i = 1'b0;

    drive(1'b1, 62'h10, 32'h0050_0093, 1'b0, 1'b0); step();
    chk("addi_pc", 64'(d_pc_o), 64'h10);
    chk("addi_rd", 64'(d_rd_o), 64'd1);
    chk("addi_class", 64'(d_class_o), 64'd8);
    chk("addi_fmt", 64'(d_fmt_o), 64'd1);
    chk("addi_imm", d_imm_o, 64'd5);
    chk("addi_we", 64'(d_we_o), 64'd1);

    drive(1'b1, 62'h11, 32'h8000_0137, 1'b0, 1'b0); step();
    chk("lui_imm", d_imm_o, 64'hFFFF_FFFF_8000_0000);
    chk("lui_class", 64'(d_class_o), 64'd1);
    drive(1'b1, 62'h12, 32'hFE00_0EE3, 1'b0, 1'b0); step();
    chk("beq_imm", d_imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_class", 64'(d_class_o), 64'd5);
    chk("beq_we", 64'(d_we_o), 64'd0);

    // Stall with one fetch into the skid, then release
    drive(1'b1, 62'h20, 32'h00A0_0113, 1'b1, 1'b0); step();
    chk("skid_hold_pc", 64'(d_pc_o), 64'h12);
    chk("skid_hold", 64'(f_hold_o), 64'd1);
    drive(1'b0, 62'h0, 32'h0, 1'b1, 1'b0); step();
    drive(1'b0, 62'h0, 32'h0, 1'b0, 1'b0); step();
    chk("skid_out_pc", 64'(d_pc_o), 64'h20);
    chk("skid_out_hold", 64'(f_hold_o), 64'd0);

    // Two fetches during one stall: second is lost
    drive(1'b1, 62'h30, 32'h0000_0013, 1'b1, 1'b0); step();
    drive(1'b1, 62'h31, 32'h0010_0093, 1'b1, 1'b0); step();
    chk("ovr_set", 64'(d_overrun_o), 64'd1);
    chk("ovr_pc", 64'(d_pc_o), 64'h20);

    // Flush with a simultaneous fetch
    drive(1'b1, 62'h40, 32'h0050_0093, 1'b1, 1'b1); step();
    chk("fl_valid", 64'(d_valid_o), 64'd0);
    chk("fl_hold", 64'(f_hold_o), 64'd0);
    chk("fl_ovr", 64'(d_overrun_o), 64'd0);

    drive(1'b1, 62'h50, 32'h0000_0000, 1'b0, 1'b0); step();
    chk("ill0", 64'(d_illegal_o), 64'd1);
    chk("ill0_class", 64'(d_class_o), 64'd15);
    drive(1'b1, 62'h51, 32'hFFFF_FFFF, 1'b0, 1'b0); step();
    chk("ill1", 64'(d_illegal_o), 64'd1);
    chk("ill1_we", 64'(d_we_o), 64'd0);
    drive(1'b1, 62'h52, 32'h0000_0013, 1'b0, 1'b0); step();
    chk("nop_we", 64'(d_we_o), 64'd0);
    chk("nop_ill", 64'(d_illegal_o), 64'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom();
      if ($urandom_range(3, 0) != 0) r[6:0] = OPC_TAB[$urandom_range(12, 0)];
      reset_i = ($urandom_range(99, 0) == 0);
      drive($urandom_range(9, 0) < 7, 62'({$urandom(), $urandom()}), r,
            $urandom_range(9, 0) < 4, $urandom_range(19, 0) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
